// File: rtl/gf16_poly_mac_seq.sv
// Sequential GF(16) polynomial multiply-accumulate: P(x) = Q(x)*D(x) + R(x).
// Coefficients in exponent form (15 = zero); one quotient coefficient per cycle.
module gf16_poly_mac_seq #(
    parameter int N = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*N-1:0]         in_quotient,
    input  logic [4*N-1:0]         in_divisor,
    input  logic [4*N-1:0]         in_remainder,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*(2*N-1)-1:0]   out_product
);

    localparam int W  = 4 * N;
    localparam int PW = 4 * (2 * N - 1);
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t          r_state, w_state_next;
    logic [W-1:0]    r_q, r_d;
    logic [PW-1:0]   r_acc, r_product;
    logic [KW-1:0]   r_k;
    logic            r_in_ready, r_out_valid;

    logic [W-1:0]    w_rem_bin;
    logic [PW-1:0]   w_pp, w_acc_next, w_prod_exp;
    logic [3:0]      w_qk;
    logic            w_accept, w_last;

    function automatic logic [3:0] exp2bin(input logic [3:0] e);
        case (e)
            4'd0:    return 4'h1;
            4'd1:    return 4'h2;
            4'd2:    return 4'h4;
            4'd3:    return 4'h8;
            4'd4:    return 4'h3;
            4'd5:    return 4'h6;
            4'd6:    return 4'hC;
            4'd7:    return 4'hB;
            4'd8:    return 4'h5;
            4'd9:    return 4'hA;
            4'd10:   return 4'h7;
            4'd11:   return 4'hE;
            4'd12:   return 4'hF;
            4'd13:   return 4'hD;
            4'd14:   return 4'h9;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [3:0] bin2exp(input logic [3:0] b);
        case (b)
            4'h1:    return 4'd0;
            4'h2:    return 4'd1;
            4'h3:    return 4'd4;
            4'h4:    return 4'd2;
            4'h5:    return 4'd8;
            4'h6:    return 4'd5;
            4'h7:    return 4'd10;
            4'h8:    return 4'd3;
            4'h9:    return 4'd14;
            4'hA:    return 4'd9;
            4'hB:    return 4'd7;
            4'hC:    return 4'd6;
            4'hD:    return 4'd13;
            4'hE:    return 4'd11;
            4'hF:    return 4'd12;
            default: return 4'd15;
        endcase
    endfunction

    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (a == 4'hF || b == 4'hF) return 4'hF;
        if (s >= 5'd15) s = s - 5'd15;
        return s[3:0];
    endfunction

    assign w_accept = in_valid && r_in_ready;
    assign w_last   = (r_k == KW'(N - 1));

    // Partial product Q[k]*D(x) is built at degree 0 and shifted up by k coefficients.
    always_comb begin
        w_qk      = r_q[4*r_k +: 4];
        w_pp      = '0;
        w_rem_bin = '0;
        for (int unsigned j = 0; j < N; j++) begin
            w_pp[4*j +: 4]      = exp2bin(gf_mul(w_qk, r_d[4*j +: 4]));
            w_rem_bin[4*j +: 4] = exp2bin(in_remainder[4*j +: 4]);
        end
        w_acc_next = r_acc ^ (w_pp << (4 * r_k));
        w_prod_exp = '0;
        for (int unsigned i = 0; i < 2 * N - 1; i++) begin
            w_prod_exp[4*i +: 4] = bin2exp(w_acc_next[4*i +: 4]);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = MAC;
            MAC:     if (w_last) w_state_next = OUT;
            OUT:     if (r_out_valid && out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_q         <= '0;
            r_d         <= '0;
            r_acc       <= '0;
            r_k         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_product   <= '1;
        end else begin
            r_state     <= w_state_next;
            r_in_ready  <= (w_state_next == IDLE);
            r_out_valid <= (w_state_next == OUT);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_q            <= in_quotient;
                        r_d            <= in_divisor;
                        r_acc          <= '0;
                        r_acc[W-1:0]   <= w_rem_bin;
                        r_k            <= '0;
                    end
                end
                MAC: begin
                    r_acc <= w_acc_next;
                    if (w_last) r_product <= w_prod_exp;
                    else        r_k       <= r_k + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_product = r_product;

endmodule
